// File: rtl/fpu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// fpu_issue_ctrl
//
// Initiator-side sequencer for the FPU start/done handshake. It accepts one
// FP request at a time from the core, registers the operands and holds
// fpu_start high until the FPU reports done. It then returns the result to
// writeback over a valid/ready interface and accrues the exception flags
// into the fflags CSR image. A watchdog aborts an operation that never
// completes, and a flush kills the operation while it is still in flight.
//
// Ports
//   clk, reset         system clock, synchronous active-high reset
//   req_*              core request (valid/ready, op, rm, rs1, rs2, rs2_lsb, rd)
//   flush              kill the in-flight operation (honoured only while BUSY)
//   fpu_*  (out)       start, op, rm, A, B, rs2_lsb towards the FPU
//   fpu_out/done/flags FPU result, completion strobe, {NV,DZ,OF,UF,NX}
//   resp_*             writeback response (valid/ready, data, rd)
//   fflags, fflags_clr accrued exception flags and CSR clear strobe
//   timeout_err        one-cycle pulse when the watchdog aborts an operation
// -----------------------------------------------------------------------------
module fpu_issue_ctrl #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_op,
  input  logic [2:0]  req_rm,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  input  logic        req_rs2_lsb,
  input  logic [4:0]  req_rd,
  input  logic        flush,
  output logic        fpu_start,
  output logic [4:0]  fpu_op,
  output logic [2:0]  fpu_rm,
  output logic [31:0] fpu_A,
  output logic [31:0] fpu_B,
  output logic        fpu_rs2_lsb,
  input  logic [31:0] fpu_out,
  input  logic        fpu_done,
  input  logic [4:0]  fpu_flags,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic [4:0]  resp_rd,
  output logic [4:0]  fflags,
  input  logic        fflags_clr,
  output logic        timeout_err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Last BUSY cycle the watchdog tolerates: the counter is 0 in the first
  // BUSY cycle, so this value is reached in BUSY cycle TIMEOUT_CYCLES.
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_fpu_start;
  logic [4:0]       r_op;
  logic [2:0]       r_rm;
  logic [31:0]      r_a;
  logic [31:0]      r_b;
  logic             r_rs2_lsb;
  logic [4:0]       r_rd;
  logic [31:0]      r_resp_data;
  logic [4:0]       r_fflags;
  logic             r_timeout_err;

  logic [1:0]       w_state_nxt;
  logic             w_accept;
  logic             w_busy;
  logic             w_flush;
  logic             w_capture;
  logic             w_timeout;
  logic             w_resp_hs;
  logic [4:0]       w_cap_flags;

  assign w_busy    = (r_state == ST_BUSY);
  assign w_accept  = (r_state == ST_IDLE) && req_valid;
  // flush outranks a same-cycle done; done outranks the watchdog, so a
  // completion in the very last allowed cycle still returns its result.
  assign w_flush   = w_busy && flush;
  assign w_capture = w_busy && !flush && fpu_done;
  assign w_timeout = w_busy && !flush && !fpu_done && (r_cnt == TIMEOUT_LAST);
  assign w_resp_hs = (r_state == ST_RESP) && resp_ready;

  assign w_cap_flags = w_capture ? fpu_flags : 5'b0_0000;

  // NOTE: every signal assigned in always_comb gets a default first so that
  // no path through the case leaves it unassigned and infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)                w_state_nxt = ST_BUSY;
      ST_BUSY: begin
        if (w_flush)                        w_state_nxt = ST_IDLE;
        else if (w_capture || w_timeout)    w_state_nxt = ST_RESP;
      end
      ST_RESP: if (w_resp_hs)               w_state_nxt = ST_IDLE;
      default:                              w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: all state is updated with non-blocking assignments so every
  // register samples the pre-edge values and ordering inside the block
  // does not matter. Reset here is synchronous, so it sits inside the
  // clocked branch rather than in the sensitivity list.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_fpu_start   <= 1'b0;
      r_op          <= '0;
      r_rm          <= '0;
      r_a           <= '0;
      r_b           <= '0;
      r_rs2_lsb     <= 1'b0;
      r_rd          <= '0;
      r_resp_data   <= '0;
      r_fflags      <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      // start is a pure register so the FPU sees a glitch-free level that
      // is high for exactly the BUSY cycles and low in RESP/IDLE.
      r_fpu_start   <= (w_state_nxt == ST_BUSY);
      r_timeout_err <= w_timeout;
      // A clear concurrent with a capture leaves only the new flags.
      r_fflags      <= (fflags_clr ? 5'b0_0000 : r_fflags) | w_cap_flags;

      // Operands are loaded only on acceptance, so they stay frozen for the
      // whole operation and for the response phase.
      if (w_accept) begin
        r_op      <= req_op;
        r_rm      <= req_rm;
        r_a       <= req_rs1;
        r_b       <= req_rs2;
        r_rs2_lsb <= req_rs2_lsb;
        r_rd      <= req_rd;
        r_cnt     <= '0;
      end else if (w_busy) begin
        r_cnt     <= r_cnt + CNT_W'(1);
      end

      if (w_capture) begin
        r_resp_data <= fpu_out;
      end else if (w_timeout) begin
        r_resp_data <= '0;
      end
    end
  end

  assign req_ready   = (r_state == ST_IDLE);
  assign resp_valid  = (r_state == ST_RESP);
  assign fpu_start   = r_fpu_start;
  assign fpu_op      = r_op;
  assign fpu_rm      = r_rm;
  assign fpu_A       = r_a;
  assign fpu_B       = r_b;
  assign fpu_rs2_lsb = r_rs2_lsb;
  assign resp_data   = r_resp_data;
  assign resp_rd     = r_rd;
  assign fflags      = r_fflags;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fpu_issue_ctrl
//
// Directed bench for fpu_issue_ctrl. The FPU side is driven inline by the
// stimulus sequence; expected responses are queued when a request is issued
// and popped when writeback takes the response.
// -----------------------------------------------------------------------------
module tb_fpu_issue_ctrl;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_op;
  logic [2:0]  req_rm;
  logic [31:0] req_rs1;
  logic [31:0] req_rs2;
  logic        req_rs2_lsb;
  logic [4:0]  req_rd;
  logic        flush;
  logic        fpu_start;
  logic [4:0]  fpu_op;
  logic [2:0]  fpu_rm;
  logic [31:0] fpu_A;
  logic [31:0] fpu_B;
  logic        fpu_rs2_lsb;
  logic [31:0] fpu_out;
  logic        fpu_done;
  logic [4:0]  fpu_flags;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic [4:0]  fflags;
  logic        fflags_clr;
  logic        timeout_err;

  int n_checks = 0;
  int n_errors = 0;

  // Scoreboard entry: {rd, data}
  logic [36:0] sb_q[$];

  fpu_issue_ctrl #(.TIMEOUT_CYCLES(64), .CNT_W(7)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_rm     (req_rm),
    .req_rs1    (req_rs1),
    .req_rs2    (req_rs2),
    .req_rs2_lsb(req_rs2_lsb),
    .req_rd     (req_rd),
    .flush      (flush),
    .fpu_start  (fpu_start),
    .fpu_op     (fpu_op),
    .fpu_rm     (fpu_rm),
    .fpu_A      (fpu_A),
    .fpu_B      (fpu_B),
    .fpu_rs2_lsb(fpu_rs2_lsb),
    .fpu_out    (fpu_out),
    .fpu_done   (fpu_done),
    .fpu_flags  (fpu_flags),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_rd    (resp_rd),
    .fflags     (fflags),
    .fflags_clr (fflags_clr),
    .timeout_err(timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the sequence itself ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "simulation time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] op, input logic [2:0] rm, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd);
    check("req_ready_before_issue", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_rm    = rm;
    req_rs1   = a;
    req_rs2   = b;
    req_rd    = rd;
    step();
    req_valid = 1'b0;
  endtask

  // Wait (bounded) for resp_valid, hold off writeback for 'hold' cycles,
  // then complete the handshake and compare against the scoreboard.
  task automatic take_resp(input int hold, input string tag);
    logic [36:0] exp;
    int waited;
    waited = 0;
    while (!resp_valid && waited < 100) begin
      step();
      waited++;
    end
    check({tag, "_resp_valid"}, {31'b0, resp_valid}, 32'd1);
    if (sb_q.size() == 0) begin
      check({tag, "_scoreboard_empty"}, 32'd0, 32'd1);
      return;
    end
    exp = sb_q.pop_front();
    for (int i = 0; i < hold; i++) begin
      resp_ready = 1'b0;
      check({tag, "_hold_valid"}, {31'b0, resp_valid}, 32'd1);
      check({tag, "_hold_data"}, resp_data, exp[31:0]);
      check({tag, "_hold_rd"}, {27'b0, resp_rd}, {27'b0, exp[36:32]});
      check({tag, "_hold_req_ready"}, {31'b0, req_ready}, 32'd0);
      step();
    end
    resp_ready = 1'b1;
    check({tag, "_data"}, resp_data, exp[31:0]);
    check({tag, "_rd"}, {27'b0, resp_rd}, {27'b0, exp[36:32]});
    check({tag, "_hs_req_ready"}, {31'b0, req_ready}, 32'd0);
    step();
    resp_ready = 1'b0;
    check({tag, "_after_valid"}, {31'b0, resp_valid}, 32'd0);
    check({tag, "_after_req_ready"}, {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    int starts;

    reset       = 1'b1;
    req_valid   = 1'b0;
    req_op      = '0;
    req_rm      = '0;
    req_rs1     = '0;
    req_rs2     = '0;
    req_rs2_lsb = 1'b0;
    req_rd      = '0;
    flush       = 1'b0;
    fpu_out     = '0;
    fpu_done    = 1'b0;
    fpu_flags   = '0;
    resp_ready  = 1'b0;
    fflags_clr  = 1'b0;
    step();
    step();
    reset = 1'b0;

    // ---- reset state ----
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_fpu_start", {31'b0, fpu_start}, 32'd0);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_timeout_err", {31'b0, timeout_err}, 32'd0);
    check("rst_fflags", {27'b0, fflags}, 32'd0);
    check("rst_fpu_A", fpu_A, 32'd0);
    check("rst_resp_data", resp_data, 32'd0);

    // ---- FADD, single-cycle completion ----
    fpu_done  = 1'b1;
    fpu_out   = 32'h4040_0000;
    fpu_flags = 5'b00000;
    sb_q.push_back({5'd1, 32'h4040_0000});
    issue(5'b00000, 3'b000, 32'h3F80_0000, 32'h4000_0000, 5'd1);
    check("fadd_start", {31'b0, fpu_start}, 32'd1);
    check("fadd_req_ready_busy", {31'b0, req_ready}, 32'd0);
    check("fadd_A", fpu_A, 32'h3F80_0000);
    check("fadd_B", fpu_B, 32'h4000_0000);
    check("fadd_op", {27'b0, fpu_op}, 32'd0);
    check("fadd_valid_n1", {31'b0, resp_valid}, 32'd0);
    step();
    fpu_done = 1'b0;
    check("fadd_valid_n2", {31'b0, resp_valid}, 32'd1);
    check("fadd_start_resp", {31'b0, fpu_start}, 32'd0);
    check("fadd_fflags", {27'b0, fflags}, 32'd0);
    take_resp(0, "fadd");

    // ---- FDIV by zero, done after 20 BUSY cycles, writeback stalls 5 cycles ----
    sb_q.push_back({5'd2, 32'h7F80_0000});
    issue(5'b00011, 3'b001, 32'h3F80_0000, 32'h0000_0000, 5'd2);
    check("fdiv_op", {27'b0, fpu_op}, 32'd3);
    check("fdiv_rm", {29'b0, fpu_rm}, 32'd1);
    starts = 0;
    for (int i = 1; i <= 19; i++) begin
      if (fpu_start) starts++;
      step();
    end
    if (fpu_start) starts++;
    fpu_done  = 1'b1;
    fpu_out   = 32'h7F80_0000;
    fpu_flags = 5'b01000;
    step();
    fpu_done  = 1'b0;
    fpu_flags = 5'b00000;
    check("fdiv_start_cycles", starts, 32'd20);
    check("fdiv_start_resp", {31'b0, fpu_start}, 32'd0);
    check("fdiv_fflags", {27'b0, fflags}, 32'b01000);
    check("fdiv_A_stable", fpu_A, 32'h3F80_0000);
    take_resp(5, "fdiv");

    // ---- flush on the 3rd BUSY cycle; flush beats a same-cycle done ----
    issue(5'b00011, 3'b000, 32'h4100_0000, 32'h4000_0000, 5'd3);
    step();
    step();
    check("flush_start_busy3", {31'b0, fpu_start}, 32'd1);
    flush     = 1'b1;
    fpu_done  = 1'b1;
    fpu_out   = 32'hDEAD_BEEF;
    fpu_flags = 5'b11111;
    step();
    flush     = 1'b0;
    fpu_done  = 1'b0;
    fpu_flags = 5'b00000;
    check("flush_start_drop", {31'b0, fpu_start}, 32'd0);
    check("flush_no_valid", {31'b0, resp_valid}, 32'd0);
    check("flush_fflags", {27'b0, fflags}, 32'b01000);
    check("flush_resp_data", resp_data, 32'h7F80_0000);
    step();
    check("flush_no_valid_later", {31'b0, resp_valid}, 32'd0);

    // next request after flush proceeds normally and accrues NX
    fpu_done  = 1'b1;
    fpu_out   = 32'h1234_5678;
    fpu_flags = 5'b00001;
    sb_q.push_back({5'd4, 32'h1234_5678});
    issue(5'b00000, 3'b000, 32'h1111_1111, 32'h2222_2222, 5'd4);
    step();
    fpu_done  = 1'b0;
    fpu_flags = 5'b00000;
    check("postflush_fflags", {27'b0, fflags}, 32'b01001);
    take_resp(0, "postflush");

    // ---- watchdog: done never arrives ----
    sb_q.push_back({5'd5, 32'h0000_0000});
    issue(5'b00011, 3'b000, 32'h4000_0000, 32'h4000_0000, 5'd5);
    starts = 0;
    for (int i = 1; i <= 63; i++) begin
      if (fpu_start) starts++;
      if (timeout_err) starts = starts + 1000;
      step();
    end
    check("to_start_cycles_63", starts, 32'd63);
    check("to_start_busy64", {31'b0, fpu_start}, 32'd1);
    check("to_no_valid_busy64", {31'b0, resp_valid}, 32'd0);
    step();
    check("to_pulse", {31'b0, timeout_err}, 32'd1);
    check("to_valid", {31'b0, resp_valid}, 32'd1);
    check("to_resp_data", resp_data, 32'd0);
    check("to_fflags", {27'b0, fflags}, 32'b01001);
    step();
    check("to_pulse_end", {31'b0, timeout_err}, 32'd0);
    take_resp(0, "timeout");

    // ---- fflags clear alone, then clear concurrent with a capture ----
    fflags_clr = 1'b1;
    step();
    fflags_clr = 1'b0;
    check("clr_alone", {27'b0, fflags}, 32'd0);
    fpu_done  = 1'b1;
    fpu_out   = 32'h3F00_0001;
    fpu_flags = 5'b00001;
    sb_q.push_back({5'd6, 32'h3F00_0001});
    issue(5'b00001, 3'b010, 32'h3F00_0000, 32'h3300_0000, 5'd6);
    step();
    fpu_done  = 1'b0;
    check("nx_fflags", {27'b0, fflags}, 32'b00001);
    take_resp(0, "nx");

    sb_q.push_back({5'd7, 32'h7FC0_0000});
    issue(5'b00011, 3'b000, 32'h0000_0000, 32'h0000_0000, 5'd7);
    fpu_done   = 1'b1;
    fpu_out    = 32'h7FC0_0000;
    fpu_flags  = 5'b10000;
    fflags_clr = 1'b1;
    step();
    fpu_done   = 1'b0;
    fpu_flags  = 5'b00000;
    fflags_clr = 1'b0;
    check("clr_with_capture", {27'b0, fflags}, 32'b10000);
    take_resp(0, "nv");

    // ---- reset in the middle of BUSY ----
    issue(5'b00011, 3'b011, 32'hAAAA_AAAA, 32'h5555_5555, 5'd8);
    step();
    check("rst_mid_busy_start", {31'b0, fpu_start}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_mid_start", {31'b0, fpu_start}, 32'd0);
    check("rst_mid_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_mid_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_mid_fflags", {27'b0, fflags}, 32'd0);
    check("rst_mid_A", fpu_A, 32'd0);
    check("rst_mid_B", fpu_B, 32'd0);
    check("rst_mid_op", {27'b0, fpu_op}, 32'd0);
    check("rst_mid_rm", {29'b0, fpu_rm}, 32'd0);
    check("rst_mid_resp_data", resp_data, 32'd0);
    check("rst_mid_resp_rd", {27'b0, resp_rd}, 32'd0);
    check("rst_mid_timeout", {31'b0, timeout_err}, 32'd0);
    step();
    check("rst_mid_valid_later", {31'b0, resp_valid}, 32'd0);
    check("scoreboard_drained", sb_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fpu_issue_ctrl.md
Name: fpu_issue_ctrl

Overview:
Initiator-side sequencer for the FPU arithmetic unit's start/done handshake.
- Accepts one FP request at a time from the core pipeline through a valid/ready interface.
- Registers the operands and drives the FPU's start, op, rounding-mode, operand and rs2_lsb inputs.
- Holds start high until the FPU raises done, then captures the result and exception flags.
- Returns the result to writeback through a valid/ready interface and accrues the flags into the fflags CSR image.

Parameters:
TIMEOUT_CYCLES, 64, maximum cycles in BUSY without fpu_done before the operation is aborted.
CNT_W, 7, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  core request valid
req_ready  out  1  request accepted when high together with req_valid
req_op  in  5  FPU op code
req_rm  in  3  instruction rounding mode
req_rs1  in  32  operand A
req_rs2  in  32  operand B
req_rs2_lsb  in  1  signed/unsigned select for conversions
req_rd  in  5  destination register tag
flush  in  1  kill the in-flight operation
fpu_start  out  1  to FPU start
fpu_op  out  5  to FPU op
fpu_rm  out  3  to FPU rounding_mode
fpu_A  out  32  to FPU A
fpu_B  out  32  to FPU B
fpu_rs2_lsb  out  1  to FPU rs2_lsb
fpu_out  in  32  FPU result
fpu_done  in  1  FPU done
fpu_flags  in  5  {invalid, div_by_zero, overflow, underflow, inexact}
resp_valid  out  1  result valid
resp_ready  in  1  writeback accepts result
resp_data  out  32  captured result
resp_rd  out  5  captured destination tag
fflags  out  5  accrued flags {NV,DZ,OF,UF,NX}
fflags_clr  in  1  CSR write clears accrued flags
timeout_err  out  1  one-cycle pulse on abort

Behaviour:
- Reset values: state IDLE; fpu_start=0; resp_valid=0; timeout_err=0; fflags=0; all captured registers (fpu_op, fpu_rm, fpu_A, fpu_B, fpu_rs2_lsb, resp_data, resp_rd) = 0. Reset asserted mid-operation returns to IDLE the next cycle: no response, no flag update.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid: register op, rm, rs1, rs2, rs2_lsb and rd; clear the counter; go to BUSY.
- BUSY:
  - req_ready=0; fpu_start=1 (registered output, high for the whole state); counter increments each cycle.
  - fpu_done=1 sampled: capture fpu_out into resp_data; accrue fpu_flags; go to RESP. fpu_start is 0 in RESP.
  - flush=1: go to IDLE, fpu_start=0, nothing captured. flush takes priority over a same-cycle fpu_done.
  - Counter reaches TIMEOUT_CYCLES-1 without done: pulse timeout_err; resp_data=0; no flag update; go to RESP.
- RESP:
  - resp_valid=1; resp_data and resp_rd are stable until handshake.
  - resp_ready=1: go to IDLE next cycle.
  - flush is ignored in RESP (result is already committed).
- fpu_start is low for at least one cycle between consecutive operations; the RESP and IDLE states guarantee this gap.
- Minimum latency: accepted at cycle N, fpu_start high at N+1, resp_valid at N+2 if done is combinational (single-cycle ops).
- Throughput: at most one operation every 3 cycles.
- fflags:
  - fflags <= (fflags_clr ? 0 : fflags) | captured_flags.
  - fflags_clr concurrent with a capture leaves only the new flags set.
  - fflags_clr alone clears to 0 the next cycle.
- Operand outputs are held constant throughout BUSY and are not updated while not in IDLE.

Test Plan:
- FADD (op 00000, rm 000): A=0x3F800000, B=0x40000000, fpu_done high in the first BUSY cycle -> resp_valid 2 cycles after acceptance; resp_data=0x40400000; fflags=0.
- FDIV (op 00011): A=0x3F800000, B=0x00000000, done after 20 cycles -> fpu_start high exactly 20 cycles; resp_data=0x7F800000; fflags=5'b01000.
- resp_ready held low 5 cycles in RESP, then high -> resp_data/resp_rd stable throughout; req_ready=0 until the cycle after the handshake.
- flush on the 3rd BUSY cycle of an FDIV -> fpu_start drops the next cycle; no resp_valid; fflags unchanged; next request accepted normally.
- fpu_done tied low, TIMEOUT_CYCLES=64 -> timeout_err pulses after 64 BUSY cycles; resp_data=0; fflags unchanged.
- fflags=5'b00001 then fflags_clr asserted in the capture cycle of an op returning invalid -> fflags=5'b10000. Also: reset mid-BUSY -> all outputs at reset values the next cycle.
